// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard unit: state encoding,
// forwarding selects, register address width and control bundle.
`timescale 1ns/1ps
package pipe_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2,
        ERR     = 2'd3
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } hz_ctrl_t;

    function automatic hz_ctrl_t ctrl_init();
        hz_ctrl_t c;
        c = '0;
        c.stall_f = 1'b1;
        c.flush_d = 1'b1;
        c.flush_e = 1'b1;
        return c;
    endfunction

    // Freeze F..M and drop whatever leaves M so nothing retires twice.
    function automatic hz_ctrl_t ctrl_wait();
        hz_ctrl_t c;
        c = '0;
        c.stall_f = 1'b1;
        c.stall_d = 1'b1;
        c.stall_e = 1'b1;
        c.stall_m = 1'b1;
        c.flush_w = 1'b1;
        return c;
    endfunction

    // A taken branch squashes the load-use victim anyway, so it wins.
    function automatic hz_ctrl_t ctrl_run(
        input logic pc_src,
        input logic lw_stall
    );
        hz_ctrl_t c;
        c = '0;
        if (pc_src) begin
            c.flush_d = 1'b1;
            c.flush_e = 1'b1;
        end else if (lw_stall) begin
            c.stall_f = 1'b1;
            c.stall_d = 1'b1;
            c.flush_e = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// ALU operand forwarding select for one execute-stage source.
// Ports: rs, rd_m, rd_w, reg_write_m, reg_write_w in; fwd out (2b).
`timescale 1ns/1ps
import pipe_pkg::*;

module fwd_select (
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    logic hit_m;
    logic hit_w;

    // x0 is hardwired zero and must never be forwarded.
    assign hit_m = reg_write_m & (rd_m != '0) & (rd_m == rs);
    assign hit_w = reg_write_w & (rd_w != '0) & (rd_w == rs);

    // M holds the younger value, so it wins over W.
    always_comb begin
        fwd = FWD_RF;
        if (hit_m) begin
            fwd = FWD_MEM;
        end else if (hit_w) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit: forwarding, load-use stall, branch flush, memory-wait
// freeze with timeout. Ports: register ids/enables, LoadE, PCSrcE,
// MemReqM/MemReadyM in; ForwardAE/BE, Stall*, Flush*, mem_timeout out.
// HAZARD_PERF_EN adds stall_cycles/flush_events counters (PERF_W bits).
`timescale 1ns/1ps
import pipe_pkg::*;

module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned PERF_W      = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       LoadE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       PCSrcE,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       mem_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_events
`endif
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(MEM_TIMEOUT);

    hz_state_e   state_q;
    hz_state_e   state_d;
    logic [15:0] wait_cnt_q;
    logic [15:0] wait_cnt_d;
    logic        timeout_q;
    hz_ctrl_t    ctrl;
    logic        lw_stall;
    logic        mem_wait;
    logic        pc_taken;

    fwd_select u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (ForwardAE)
    );

    fwd_select u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (ForwardBE)
    );

    assign lw_stall = LoadE & (RdE != '0) &
                      ((RdE == Rs1D) | (RdE == Rs2D));
    assign mem_wait = MemReqM & ~MemReadyM;

    // A branch seen during a wait stays parked in E (StallE) and is
    // picked up by the RUN rules on the ready cycle.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ctrl       = '0;
        pc_taken   = 1'b0;
        unique case (state_q)
            INIT: begin
                ctrl    = ctrl_init();
                state_d = RUN;
            end
            RUN: begin
                if (mem_wait) begin
                    ctrl       = ctrl_wait();
                    state_d    = MEMWAIT;
                    wait_cnt_d = 16'd1;
                end else begin
                    ctrl     = ctrl_run(PCSrcE, lw_stall);
                    pc_taken = PCSrcE;
                end
            end
            MEMWAIT: begin
                if (MemReadyM) begin
                    ctrl       = ctrl_run(PCSrcE, lw_stall);
                    pc_taken   = PCSrcE;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    ctrl = ctrl_wait();
                    if (wait_cnt_q == TIMEOUT_CNT) begin
                        state_d = ERR;
                    end
                    if (wait_cnt_q != 16'hFFFF) begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                end
            end
            ERR: begin
                ctrl = ctrl_wait();
            end
            default: begin
                ctrl    = ctrl_init();
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_q | (state_d == ERR);
        end
    end

    assign StallF      = ctrl.stall_f;
    assign StallD      = ctrl.stall_d;
    assign StallE      = ctrl.stall_e;
    assign StallM      = ctrl.stall_m;
    assign FlushD      = ctrl.flush_d;
    assign FlushE      = ctrl.flush_e;
    assign FlushW      = ctrl.flush_w;
    assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_q;
    logic [PERF_W-1:0] flush_q;
    logic              live;

    assign live = (state_q == RUN) | (state_q == MEMWAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (live && ctrl.stall_f) begin
                stall_q <= stall_q + PERF_W'(1);
            end
            if (pc_taken) begin
                flush_q <= flush_q + PERF_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
`else
    // Counters compiled out; keep PERF_W referenced in this build.
    if (PERF_W > 0) begin : g_perf_off
    end
    logic unused_pc_taken;
    assign unused_pc_taken = pc_taken;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: MEMWAIT cycles before a timeout error; legal range 1..65535.
REQ-002 SHALL have parameter PERF_W, default 32: width of the performance counters.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports Rs1D, Rs2D  in  5 each  decode-stage source registers.
REQ-006 SHALL have ports Rs1E, Rs2E, RdE  in  5 each  execute-stage source and destination registers.
REQ-007 SHALL have ports RdM, RdW  in  5 each  memory-stage and writeback-stage destination registers.
REQ-008 SHALL have port LoadE  in  1  execute-stage instruction is a load (ResultSrcE[0]).
REQ-009 SHALL have ports RegWriteM, RegWriteW  in  1 each  stage writes the register file.
REQ-010 SHALL have port PCSrcE  in  1  taken branch or jump resolved in execute.
REQ-011 SHALL have ports MemReqM, MemReadyM  in  1 each  data-memory access in M, and memory ready.
REQ-012 SHALL have ports ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 register file, 01 writeback, 10 memory.
REQ-013 SHALL have ports StallF, StallD, StallE, StallM  out  1 each  hold the pipeline register.
REQ-014 SHALL have ports FlushD, FlushE, FlushW  out  1 each  bubble the pipeline register.
REQ-015 SHALL have port mem_timeout  out  1  sticky error flag.

Function
REQ-016 SHALL compute ForwardAE combinationally: 10 if RegWriteM, RdM!=0 and RdM==Rs1E; else 01 if RegWriteW, RdW!=0 and RdW==Rs1E; else 00. The M stage wins when M and W both match.
REQ-017 SHALL compute ForwardBE with the REQ-016 rule, using Rs2E in place of Rs1E.
REQ-018 SHALL define lwStall = LoadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
REQ-019 SHALL define memWait = MemReqM & !MemReadyM.
REQ-020 SHALL implement states INIT, RUN, MEMWAIT, ERR, with all outputs a function of state and current inputs (Moore/Mealy mix, zero latency).
REQ-021 In INIT, SHALL drive StallF=1, FlushD=1, FlushE=1 and all other controls 0, then go to RUN unconditionally after one cycle.
REQ-022 In RUN with memWait: StallF/D/E/M=1 and FlushW=1; FlushD and FlushE SHALL be forced to 0; go to MEMWAIT; set the wait counter to 1.
REQ-023 In RUN without memWait and with PCSrcE: FlushD=1, FlushE=1, StallF=0, StallD=0. PCSrcE SHALL override lwStall.
REQ-024 In RUN with lwStall only: StallF=1, StallD=1, FlushE=1.
REQ-025 In MEMWAIT, while MemReadyM=0: same outputs as REQ-022; the counter increments (saturating); when the counter equals MEM_TIMEOUT, go to ERR.
REQ-026 In MEMWAIT, when MemReadyM=1: outputs follow RUN rules REQ-023/024, and the next state SHALL be RUN.
REQ-027 A PCSrcE asserted during MEMWAIT SHALL be held by StallE and honored on the ready cycle.
REQ-028 In ERR: StallF/D/E/M=1, FlushW=1, mem_timeout=1; the block leaves ERR only by reset.
REQ-029 SHALL keep forwarding active in every state.

Reset
REQ-030 rst_n low SHALL asynchronously force state INIT, clear the wait counter and the perf counters, and set mem_timeout=0.
REQ-031 While rst_n is low, outputs SHALL equal the INIT outputs (StallF=1, FlushD=1, FlushE=1, rest 0).
REQ-032 Reset asserted mid-MEMWAIT or in ERR SHALL abandon the wait immediately.

Configuration
REQ-033 With HAZARD_PERF_EN defined, SHALL add outputs stall_cycles and flush_events, PERF_W bits each, wrapping.
REQ-034 stall_cycles SHALL increment on each RUN/MEMWAIT cycle with StallF=1.
REQ-035 flush_events SHALL increment on each cycle where PCSrcE is honored (REQ-023).
REQ-036 Without HAZARD_PERF_EN, these ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-037 Package pipe_pkg SHALL hold: the state enum (INIT, RUN, MEMWAIT, ERR); forward constants FWD_RF=00, FWD_WB=01, FWD_MEM=10; and the register-address width 5.
REQ-038 Sub-module fwd_select (pure combinational, REQ-016 rule) SHALL be instantiated twice, once for operand A and once for operand B.

Verification
REQ-039 Reset release: first cycle has StallF=1, FlushD=1, FlushE=1; second cycle all controls 0 with no hazard.
REQ-040 RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00; with RdM=0 instead -> ForwardAE=01.
REQ-041 LoadE=1, RdE=7, Rs2D=7, PCSrcE=0 -> StallF=StallD=FlushE=1 for one cycle; same with PCSrcE=1 -> FlushD=FlushE=1, StallF=0.
REQ-042 MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> Stall F/D/E/M and FlushW high for 3 cycles, normal on cycle 4, mem_timeout=0.
REQ-043 MEM_TIMEOUT=4, MemReadyM held 0 -> mem_timeout rises after 4 wait cycles and stays high while MemReadyM later goes 1; rst_n pulse clears it.
REQ-044 HAZARD_PERF_EN defined: 2 load-use stalls, 1 taken branch, 3 wait cycles -> stall_cycles=5, flush_events=1.
